// File: rtl/alu_scheduler_if.sv
// Bundle of requester, ALU and response signals around the shared-ALU scheduler.
// The slave modport is the scheduler's view; master is the surrounding system.
interface alu_scheduler_if #(
  parameter int WIDTH = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [3:0]       req0_opcode;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [3:0]       req1_opcode;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic [3:0]       alu_opcode;
  logic [WIDTH-1:0] alu_op1;
  logic [WIDTH-1:0] alu_op2;
  logic [3:0]       alu_stin;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_stout;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic [3:0]       rsp_status;

  logic [3:0]       st0;
  logic [3:0]       st1;

  modport slave (
    input  req0_valid, req0_opcode, req0_a, req0_b,
    input  req1_valid, req1_opcode, req1_a, req1_b,
    output req0_ready, req1_ready,
    output alu_opcode, alu_op1, alu_op2, alu_stin,
    input  alu_result, alu_stout,
    output rsp_valid, rsp_id, rsp_result, rsp_status,
    input  rsp_ready,
    output st0, st1
  );

  modport master (
    output req0_valid, req0_opcode, req0_a, req0_b,
    output req1_valid, req1_opcode, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  alu_opcode, alu_op1, alu_op2, alu_stin,
    output alu_result, alu_stout,
    input  rsp_valid, rsp_id, rsp_result, rsp_status,
    output rsp_ready,
    input  st0, st1
  );
endinterface

// File: rtl/alu_scheduler.sv
// Round-robin scheduler sharing one ALU between two requesters, with a
// per-requester N/Z/C/V status context fed back as the ALU status input.
module alu_scheduler #(
  parameter int WIDTH   = 16,
  parameter int ALU_LAT = 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  alu_scheduler_if.slave bus_if
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam logic [2:0] CNT_INIT = 3'(ALU_LAT - 1);

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic             id_q, id_d;
  logic [3:0]       opcode_q, opcode_d;
  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [3:0]       rsp_status_q, rsp_status_d;
  logic [3:0]       st0_q, st0_d;
  logic [3:0]       st1_q, st1_d;

  logic             grant_id_s;
  logic             accept_s;
  logic [3:0]       sel_opcode_s;
  logic [WIDTH-1:0] sel_a_s;
  logic [WIDTH-1:0] sel_b_s;

  // Arbitration: with both valid, the requester not granted last wins
  always_comb begin
    grant_id_s   = 1'b0;
    sel_opcode_s = bus_if.req0_opcode;
    sel_a_s      = bus_if.req0_a;
    sel_b_s      = bus_if.req0_b;
    if (bus_if.req0_valid && bus_if.req1_valid) begin
      grant_id_s = ~last_q;
    end else if (bus_if.req1_valid) begin
      grant_id_s = 1'b1;
    end else begin
      grant_id_s = 1'b0;
    end
    if (grant_id_s) begin
      sel_opcode_s = bus_if.req1_opcode;
      sel_a_s      = bus_if.req1_a;
      sel_b_s      = bus_if.req1_b;
    end else begin
      sel_opcode_s = bus_if.req0_opcode;
      sel_a_s      = bus_if.req0_a;
      sel_b_s      = bus_if.req0_b;
    end
    accept_s = (state_q == IDLE) && (bus_if.req0_valid || bus_if.req1_valid) && !rst_i;
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    id_d         = id_q;
    opcode_d     = opcode_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_status_d = rsp_status_q;
    st0_d        = st0_q;
    st1_d        = st1_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          id_d     = grant_id_s;
          opcode_d = sel_opcode_s;
          op1_d    = sel_a_s;
          op2_d    = sel_b_s;
          cnt_d    = CNT_INIT;
          state_d  = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (cnt_q == 3'd0) begin
          rsp_valid_d  = 1'b1;
          rsp_id_d     = id_q;
          rsp_result_d = bus_if.alu_result;
          rsp_status_d = bus_if.alu_stout;
          last_d       = id_q;
          state_d      = RESP;
          // Only the owner's context is written; the other one is untouched.
          if (id_q) begin
            st1_d = bus_if.alu_stout;
          end else begin
            st0_d = bus_if.alu_stout;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (bus_if.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      id_q         <= 1'b0;
      opcode_q     <= 4'd0;
      op1_q        <= '0;
      op2_q        <= '0;
      cnt_q        <= 3'd0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_status_q <= 4'd0;
      st0_q        <= 4'd0;
      st1_q        <= 4'd0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      id_q         <= id_d;
      opcode_q     <= opcode_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_status_q <= rsp_status_d;
      st0_q        <= st0_d;
      st1_q        <= st1_d;
    end
  end

  assign bus_if.req0_ready = accept_s & ~grant_id_s;
  assign bus_if.req1_ready = accept_s & grant_id_s;

  // ALU inputs come straight from the latch registers, so they never toggle between ops.
  assign bus_if.alu_opcode = opcode_q;
  assign bus_if.alu_op1    = op1_q;
  assign bus_if.alu_op2    = op2_q;
  assign bus_if.alu_stin   = id_q ? st1_q : st0_q;

  assign bus_if.rsp_valid  = rsp_valid_q;
  assign bus_if.rsp_id     = rsp_id_q;
  assign bus_if.rsp_result = rsp_result_q;
  assign bus_if.rsp_status = rsp_status_q;
  assign bus_if.st0        = st0_q;
  assign bus_if.st1        = st1_q;

endmodule
